// File: rtl/msx_bus_cycle_if.sv
// rtl/msx_bus_cycle_if.sv - host strobes, backend handshake and cycle outputs of msx_bus_cycle
interface msx_bus_cycle_if #(
   parameter int ADDR_W = 16
);
   logic              ena;
   logic              sltsl_n;
   logic              iorq_n;
   logic              rd_n;
   logic              wr_n;
   logic              m1_n;
   logic [ADDR_W-1:0] addr_in;
   logic [7:0]        data_in;
   logic              req;
   logic              ack;
   logic              cyc_io;
   logic              cyc_wr;
   logic [ADDR_W-1:0] cyc_addr;
   logic [7:0]        cyc_wdata;
   logic [7:0]        rdata;
   logic [7:0]        data_out;
   logic              data_oe;
   logic              wait_n;
   logic              timeout;

   // Drives strobes/address/data and answers the backend handshake.
   modport master (
      output ena, sltsl_n, iorq_n, rd_n, wr_n, m1_n, addr_in, data_in, ack, rdata,
      input  req, cyc_io, cyc_wr, cyc_addr, cyc_wdata, data_out, data_oe, wait_n, timeout
   );

   // The cycle sequencer.
   modport slave (
      input  ena, sltsl_n, iorq_n, rd_n, wr_n, m1_n, addr_in, data_in, ack, rdata,
      output req, cyc_io, cyc_wr, cyc_addr, cyc_wdata, data_out, data_oe, wait_n, timeout
   );
endinterface

// File: rtl/msx_bus_cycle.sv
// rtl/msx_bus_cycle.sv - MSX cartridge bus cycle classifier, WAIT generator and backend handshake
module msx_bus_cycle #(
   parameter int ADDR_W       = 16,
   parameter int SETTLE       = 2,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   msx_bus_cycle_if.slave    bus
);
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_REQ, S_HOLD} state_t;

   localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int TCNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE - 1);
   localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(WAIT_TIMEOUT - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [TCNT_W-1:0]   r_tcnt;
   logic                r_cyc_io;
   logic                r_cyc_wr;
   logic [ADDR_W-1:0]   r_cyc_addr;
   logic [7:0]          r_cyc_wdata;
   logic [7:0]          r_data_out;
   logic                r_timeout;

   logic w_mem;
   logic w_io;
   logic w_cond;
   logic w_latch;
   logic w_ack_take;
   logic w_tmo;
   logic w_cnt_inc;
   logic w_tcnt_inc;

   // Memory beats IO; INTA (iorq+m1 both low) is excluded from IO.
   assign w_mem  = !bus.sltsl_n && (!bus.rd_n || !bus.wr_n);
   assign w_io   = !bus.iorq_n && bus.m1_n && (!bus.rd_n || !bus.wr_n);
   assign w_cond = w_mem || w_io;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and per-edge action strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_ack_take  = 1'b0;
      w_tmo       = 1'b0;
      w_cnt_inc   = 1'b0;
      w_tcnt_inc  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.ena && w_cond) w_state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (bus.ena) begin
               if (!w_cond) begin
                  w_state_nxt = S_IDLE;
               end else if (r_cnt == SETTLE_LAST) begin
                  w_latch     = 1'b1;
                  w_state_nxt = S_REQ;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         S_REQ: begin
            // ack is checked first so a same-cycle ack suppresses the timeout.
            if (bus.ack) begin
               w_ack_take  = 1'b1;
               w_state_nxt = S_HOLD;
            end else if (r_tcnt == TIMEOUT_LAST) begin
               w_tmo       = 1'b1;
               w_state_nxt = S_HOLD;
            end else begin
               w_tcnt_inc = 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.ena && bus.rd_n && bus.wr_n) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Settle and timeout counters; settle count is held at zero while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_tcnt <= '0;
      end else begin
         if (r_state == S_IDLE) r_cnt <= '0;
         else if (w_cnt_inc)    r_cnt <= r_cnt + 1'b1;
         if (w_latch)           r_tcnt <= '0;
         else if (w_tcnt_inc)   r_tcnt <= r_tcnt + 1'b1;
      end
   end

   // Cycle latch, read data return and timeout pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cyc_io    <= 1'b0;
         r_cyc_wr    <= 1'b0;
         r_cyc_addr  <= '0;
         r_cyc_wdata <= '0;
         r_data_out  <= 8'hFF;
         r_timeout   <= 1'b0;
      end else begin
         r_timeout <= w_tmo;
         if (w_latch) begin
            r_cyc_io    <= !w_mem;
            r_cyc_wr    <= bus.rd_n && !bus.wr_n;
            r_cyc_addr  <= bus.addr_in;
            r_cyc_wdata <= bus.data_in;
         end
         if (w_ack_take && !r_cyc_wr) r_data_out <= bus.rdata;
         else if (w_tmo)              r_data_out <= 8'hFF;
      end
   end

   assign bus.req       = (r_state == S_REQ);
   assign bus.wait_n    = !((r_state == S_SETTLE) || (r_state == S_REQ));
   assign bus.data_oe   = (r_state == S_HOLD) && !r_cyc_wr;
   assign bus.cyc_io    = r_cyc_io;
   assign bus.cyc_wr    = r_cyc_wr;
   assign bus.cyc_addr  = r_cyc_addr;
   assign bus.cyc_wdata = r_cyc_wdata;
   assign bus.data_out  = r_data_out;
   assign bus.timeout   = r_timeout;
endmodule
